// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU stepping-clock generator.
// Holds the FSM state encoding, the step counter width and a small
// helper used to size the shared FSM counter.
package cpu_ctrl_pkg;

  localparam int STEP_CNT_W = 16;

  // RUN exists in the encoding in every build so debug tooling sees one
  // stable state map; it is only reachable with auto-run compiled in.
  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PULSE        = 3'd2,
    HELD         = 3'd3,
    RELEASE_WAIT = 3'd4,
    RUN          = 3'd5
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/step_clk_gen_if.sv
// Signal bundle between the front panel / CPU side and step_clk_gen.
// master = front panel side (drives raw button and run switch),
// slave  = step_clk_gen.
// There is no valid/ready handshake here: btn_step and run are raw level
// inputs sampled every clk, and clkin_out/step_cnt/busy are registered
// level outputs that are valid every cycle. The *_dbg signals expose the
// FSM state and the synchronized inputs for observation only.
interface step_clk_gen_if;
  import cpu_ctrl_pkg::*;

  logic                  btn_step;
  logic                  run;
  logic                  clkin_out;
  logic [STEP_CNT_W-1:0] step_cnt;
  logic                  busy;
  state_t                state_dbg;
  logic                  btn_sync_dbg;
  logic                  run_sync_dbg;

  modport master (
    output btn_step,
    output run,
    input  clkin_out,
    input  step_cnt,
    input  busy,
    input  state_dbg,
    input  btn_sync_dbg,
    input  run_sync_dbg
  );

  modport slave (
    input  btn_step,
    input  run,
    output clkin_out,
    output step_cnt,
    output busy,
    output state_dbg,
    output btn_sync_dbg,
    output run_sync_dbg
  );

endinterface

// File: rtl/step_clk_gen_sync_2ff.sv
// Two-flop synchronizer for one asynchronous level input.
// Both flops clear to 0 on the asynchronous active-low reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/step_clk_gen.sv
// CPU stepping clock generator: one debounced push-button press gives one
// PULSE_CYCLES-wide registered high pulse on clkin_out and bumps step_cnt.
// Optional free-running mode is compiled in with STEP_CLK_GEN_AUTO_RUN_EN;
// without it the run input is synchronized but only visible on debug.
module step_clk_gen
  import cpu_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PULSE_CYCLES    = 4,
  parameter int RUN_DIV         = 50000000
) (
  input  logic           clk,
  input  logic           reset,
  step_clk_gen_if.slave  bus
);

  // One counter is shared by every state, so size it for the longest count.
  localparam int MAX_CNT = max3(DEBOUNCE_CYCLES, PULSE_CYCLES, RUN_DIV);
  localparam int CW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] PL_LAST = CW'(PULSE_CYCLES - 1);
`ifdef STEP_CLK_GEN_AUTO_RUN_EN
  localparam logic [CW-1:0] PL_LEN   = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] RUN_LAST = CW'(RUN_DIV - 1);
`endif

  logic btn_sync;
  logic run_sync;

  sync_2ff u_btn_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (bus.btn_step),
    .q_o    (btn_sync)
  );

  sync_2ff u_run_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (bus.run),
    .q_o    (run_sync)
  );

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         cnt_inc;
  logic                  clkin_q, clkin_d;
  logic [STEP_CNT_W-1:0] step_cnt_q;
  logic                  step_inc;

  assign cnt_inc = cnt_q + CW'(1);

  // Next-state, shared counter and pulse output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clkin_d = 1'b0;
    unique case (state_q)
      IDLE: begin
`ifdef STEP_CLK_GEN_AUTO_RUN_EN
        if (run_sync)      state_d = RUN;
        else if (btn_sync) state_d = PRESS_WAIT;
`else
        if (btn_sync) state_d = PRESS_WAIT;
`endif
      end
      PRESS_WAIT: begin
        if (!btn_sync)              state_d = IDLE;
        else if (cnt_q == DB_LAST)  state_d = PULSE;
        else                        cnt_d   = cnt_inc;
      end
      PULSE: begin
        if (cnt_q == PL_LAST) state_d = HELD;
        else                  cnt_d   = cnt_inc;
      end
      HELD: begin
        if (!btn_sync) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (btn_sync)               state_d = HELD;
        else if (cnt_q == DB_LAST)  state_d = IDLE;
        else                        cnt_d   = cnt_inc;
      end
`ifdef STEP_CLK_GEN_AUTO_RUN_EN
      // cnt is the period phase; a pulse is driven while phase < PULSE_CYCLES,
      // so it appears one cycle after entry and once per RUN_DIV cycles.
      // Dropping run only leaves once no pulse is in flight.
      RUN: begin
        if (!run_sync && !(clkin_q && (cnt_q < PL_LEN))) begin
          state_d = HELD;
        end else begin
          cnt_d   = (cnt_q == RUN_LAST) ? '0 : cnt_inc;
          clkin_d = (cnt_q < PL_LEN);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (state_d == PULSE)   clkin_d = 1'b1;
  end

  // A step is counted on every rising edge of the registered step clock.
  assign step_inc = clkin_d & ~clkin_q;

  // FSM state, shared counter and the registered step clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clkin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clkin_q <= clkin_d;
    end
  end

  // Step counter, free-wrapping at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_cnt_q <= '0;
    end else if (step_inc) begin
      step_cnt_q <= step_cnt_q + STEP_CNT_W'(1);
    end
  end

  assign bus.clkin_out    = clkin_q;
  assign bus.step_cnt     = step_cnt_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.state_dbg    = state_q;
  assign bus.btn_sync_dbg = btn_sync;
  assign bus.run_sync_dbg = run_sync;

endmodule

// File: tb/tb_step_clk_gen.sv
// Bench for step_clk_gen with DEBOUNCE_CYCLES=8, PULSE_CYCLES=2, RUN_DIV=20.
// Expected step_cnt values are queued when a press (or run burst) is driven
// and checked against the DUT on each rising edge of clkin_out.
module tb_step_clk_gen;
  import cpu_ctrl_pkg::*;

  localparam int DB  = 8;
  localparam int PW  = 2;
  localparam int RD  = 20;
  localparam int W   = STEP_CNT_W;

  logic clk;
  logic reset;

  step_clk_gen_if bus_if ();

  step_clk_gen #(
    .DEBOUNCE_CYCLES (DB),
    .PULSE_CYCLES    (PW),
    .RUN_DIV         (RD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int tests_run = 0;
  int fails     = 0;
  int n_rises   = 0;
  logic [W-1:0] model_steps = '0;
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  logic prev_clkin = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_clkin = 1'b0;
    end else begin
      if (bus_if.clkin_out === 1'b1 && prev_clkin === 1'b0) begin
        n_rises++;
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected_pulse: got pulse with step_cnt=%0h, expected no pulse", bus_if.step_cnt);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if (bus_if.step_cnt !== e) begin
            fails++;
            $display("FAIL sb_step_cnt: got %0h expected %0h", bus_if.step_cnt, e);
          end
        end
      end
      prev_clkin = bus_if.clkin_out;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_press();
    model_steps = model_steps + W'(1);
    exp_q.push_back(model_steps);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    bus_if.btn_step = 1'b0;
    bus_if.run = 1'b0;
    repeat (3) tick();
    tests_run++; if (bus_if.clkin_out !== 1'b0) begin fails++; $display("FAIL reset_clkin: got %b expected 0", bus_if.clkin_out); end
    tests_run++; if (bus_if.step_cnt !== '0) begin fails++; $display("FAIL reset_step_cnt: got %0h expected 0", bus_if.step_cnt); end
    tests_run++; if (bus_if.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy); end
    tests_run++; if (bus_if.state_dbg !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", bus_if.state_dbg, IDLE); end
    bus_if.btn_step = 1'b1;
    repeat (5) tick();
    tests_run++; if (bus_if.busy !== 1'b0) begin fails++; $display("FAIL reset_hold_busy: got %b expected 0", bus_if.busy); end
    bus_if.btn_step = 1'b0;
    reset = 1'b1;
    repeat (20) tick();
    tests_run++; if (n_rises !== 0) begin fails++; $display("FAIL reset_release_pulse: got %0d pulses expected 0", n_rises); end
  endtask

  task automatic test_bounce();
    int r0;
    r0 = n_rises;
    for (int i = 0; i < 20; i++) begin
      bus_if.btn_step = ((i / 3) % 2 == 0);
      tick();
    end
    bus_if.btn_step = 1'b0;
    repeat (15) tick();
    tests_run++; if (n_rises !== r0) begin fails++; $display("FAIL bounce_pulses: got %0d expected %0d", n_rises, r0); end
    tests_run++; if (bus_if.step_cnt !== model_steps) begin fails++; $display("FAIL bounce_step_cnt: got %0h expected %0h", bus_if.step_cnt, model_steps); end
    tests_run++; if (bus_if.state_dbg !== IDLE) begin fails++; $display("FAIL bounce_state: got %0d expected %0d", bus_if.state_dbg, IDLE); end
  endtask

  task automatic test_clean_press();
    int r0, k, w;
    r0 = n_rises;
    bus_if.btn_step = 1'b1;
    expect_press();
    k = 0;
    while (k < 40 && bus_if.clkin_out !== 1'b1) begin tick(); k++; end
    tests_run++; if (k !== 11) begin fails++; $display("FAIL press_latency: got %0d cycles expected 11", k); end
    w = 0;
    while (w < 10 && bus_if.clkin_out === 1'b1) begin tick(); w++; end
    tests_run++; if (w !== PW) begin fails++; $display("FAIL press_width: got %0d expected %0d", w, PW); end
    tests_run++; if (bus_if.busy !== 1'b1) begin fails++; $display("FAIL press_busy_held: got %b expected 1", bus_if.busy); end
    if (k + w < 30) repeat (30 - k - w) tick();
    bus_if.btn_step = 1'b0;
    repeat (30) tick();
    tests_run++; if (n_rises !== r0 + 1) begin fails++; $display("FAIL press_count: got %0d expected %0d", n_rises, r0 + 1); end
    tests_run++; if (bus_if.step_cnt !== model_steps) begin fails++; $display("FAIL press_step_cnt: got %0h expected %0h", bus_if.step_cnt, model_steps); end
    tests_run++; if (bus_if.busy !== 1'b0) begin fails++; $display("FAIL press_busy_idle: got %b expected 0", bus_if.busy); end
  endtask

  task automatic test_long_hold();
    int r0;
    r0 = n_rises;
    bus_if.btn_step = 1'b1;
    expect_press();
    repeat (200) tick();
    tests_run++; if (n_rises !== r0 + 1) begin fails++; $display("FAIL hold_count: got %0d expected %0d", n_rises, r0 + 1); end
    tests_run++; if (bus_if.state_dbg !== HELD) begin fails++; $display("FAIL hold_state: got %0d expected %0d", bus_if.state_dbg, HELD); end
    bus_if.btn_step = 1'b0;
    repeat (5) tick();
    tests_run++; if (bus_if.state_dbg !== RELEASE_WAIT) begin fails++; $display("FAIL hold_relwait: got %0d expected %0d", bus_if.state_dbg, RELEASE_WAIT); end
    bus_if.btn_step = 1'b1;
    repeat (5) tick();
    tests_run++; if (bus_if.state_dbg !== HELD) begin fails++; $display("FAIL hold_rebounce: got %0d expected %0d", bus_if.state_dbg, HELD); end
    bus_if.btn_step = 1'b0;
    repeat (25) tick();
    tests_run++; if (n_rises !== r0 + 1) begin fails++; $display("FAIL hold_final_count: got %0d expected %0d", n_rises, r0 + 1); end
    tests_run++; if (bus_if.state_dbg !== IDLE) begin fails++; $display("FAIL hold_final_state: got %0d expected %0d", bus_if.state_dbg, IDLE); end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = n_rises;
    for (int n = 0; n < 3; n++) begin
      int hold, gap;
      hold = $urandom_range(20, 40);
      gap  = $urandom_range(20, 40);
      bus_if.btn_step = 1'b1;
      expect_press();
      repeat (hold) tick();
      bus_if.btn_step = 1'b0;
      repeat (gap) tick();
    end
    tests_run++; if (n_rises !== r0 + 3) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", n_rises, r0 + 3); end
    tests_run++; if (bus_if.step_cnt !== model_steps) begin fails++; $display("FAIL b2b_step_cnt: got %0h expected %0h", bus_if.step_cnt, model_steps); end
  endtask

  task automatic test_reset_mid_pulse();
    int r0, k;
    bus_if.btn_step = 1'b1;
    expect_press();
    k = 0;
    while (k < 40 && bus_if.clkin_out !== 1'b1) begin tick(); k++; end
    tests_run++; if (k !== 11) begin fails++; $display("FAIL rstmid_latency: got %0d expected 11", k); end
    tick();
    reset = 1'b0;
    bus_if.btn_step = 1'b0;
    #1;
    tests_run++; if (bus_if.clkin_out !== 1'b0) begin fails++; $display("FAIL rstmid_clkin: got %b expected 0", bus_if.clkin_out); end
    tests_run++; if (bus_if.step_cnt !== '0) begin fails++; $display("FAIL rstmid_step_cnt: got %0h expected 0", bus_if.step_cnt); end
    tests_run++; if (bus_if.busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b expected 0", bus_if.busy); end
    model_steps = '0;
    repeat (3) tick();
    reset = 1'b1;
    r0 = n_rises;
    repeat (30) tick();
    tests_run++; if (n_rises !== r0) begin fails++; $display("FAIL rstmid_no_pulse: got %0d expected %0d", n_rises, r0); end
    tests_run++; if (bus_if.state_dbg !== IDLE) begin fails++; $display("FAIL rstmid_state: got %0d expected %0d", bus_if.state_dbg, IDLE); end
  endtask

  task automatic test_wrap();
    int r0;
    r0 = n_rises;
    @(negedge clk);
    force dut.step_cnt_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.step_cnt_q;
    model_steps = 16'hFFFF;
    bus_if.btn_step = 1'b1;
    expect_press();
    repeat (30) tick();
    bus_if.btn_step = 1'b0;
    repeat (30) tick();
    tests_run++; if (bus_if.step_cnt !== 16'h0000) begin fails++; $display("FAIL wrap_step_cnt: got %0h expected 0", bus_if.step_cnt); end
    tests_run++; if (n_rises !== r0 + 1) begin fails++; $display("FAIL wrap_count: got %0d expected %0d", n_rises, r0 + 1); end
  endtask

`ifdef STEP_CLK_GEN_AUTO_RUN_EN
  task automatic test_auto_run();
    int rises, last_rise, k, w;
    logic prev;
    rises = 0; last_rise = 0; prev = 1'b0;
    bus_if.run = 1'b1;
    for (int j = 0; j < 5; j++) expect_press();
    for (int i = 1; i <= 120; i++) begin
      tick();
      if (bus_if.clkin_out === 1'b1 && prev === 1'b0) begin
        rises++;
        tests_run++;
        if (rises == 1) begin
          if (i !== 4) begin fails++; $display("FAIL run_first_rise: got cycle %0d expected 4", i); end
        end else if (i - last_rise !== RD) begin
          fails++; $display("FAIL run_period: got %0d expected %0d", i - last_rise, RD);
        end
        last_rise = i;
      end
      if (bus_if.clkin_out === 1'b0 && prev === 1'b1) begin
        tests_run++;
        if (i - last_rise !== PW) begin fails++; $display("FAIL run_width: got %0d expected %0d", i - last_rise, PW); end
      end
      prev = bus_if.clkin_out;
      if (i == 100) bus_if.run = 1'b0;
    end
    tests_run++; if (rises !== 5) begin fails++; $display("FAIL run_count: got %0d expected 5", rises); end
    tests_run++; if (bus_if.state_dbg !== IDLE) begin fails++; $display("FAIL run_end_state: got %0d expected %0d", bus_if.state_dbg, IDLE); end
    // drop run so the synchronized level falls during the first pulse
    bus_if.run = 1'b1;
    expect_press();
    tick(); tick();
    bus_if.run = 1'b0;
    k = 0;
    while (k < 20 && bus_if.clkin_out !== 1'b1) begin tick(); k++; end
    tests_run++; if (k !== 2) begin fails++; $display("FAIL rundrop_rise: got %0d expected 2", k); end
    w = 0;
    while (w < 10 && bus_if.clkin_out === 1'b1) begin tick(); w++; end
    tests_run++; if (w !== PW) begin fails++; $display("FAIL rundrop_width: got %0d expected %0d", w, PW); end
    tests_run++; if (bus_if.state_dbg !== HELD) begin fails++; $display("FAIL rundrop_state: got %0d expected %0d", bus_if.state_dbg, HELD); end
    repeat (20) tick();
    tests_run++; if (bus_if.step_cnt !== model_steps) begin fails++; $display("FAIL rundrop_step_cnt: got %0h expected %0h", bus_if.step_cnt, model_steps); end
  endtask
`endif

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_long_hold();
    test_back_to_back();
    test_reset_mid_pulse();
    test_wrap();
`ifdef STEP_CLK_GEN_AUTO_RUN_EN
    test_auto_run();
`endif
    repeat (5) tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_missing_pulses: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
